matrix_display_fmt: RTL

Downstream consumer of the matrix storage read port. On request it starts a display read of one stored matrix, pulls elements one at a time with start_disp/read_en, and converts each 8-bit value to decimal ASCII. Elements in a row are separated by spaces and each row ends with CR LF. The output is a byte stream with a valid/ready handshake for the UART TX block.

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/bin8_to_bcd3.sv | 64 ++++++
 rtl/matrix_display_fmt.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared limits, ASCII constants and the display FSM encoding
//                for the matrix display formatter.
//  Revision    : 1.0  initial release
// ============================================================================
package matrix_pkg;

    localparam int MAX_DIM = 5;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_FETCH    = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_EMIT     = 3'd5,
        ST_ABORT    = 3'd6
    } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/bin8_to_bcd3.sv
`default_nettype none
// ============================================================================
//  Module      : bin8_to_bcd3
//  Description : Combinational 8-bit binary to three decimal digits using
//                compare/subtract steps, plus the count of significant digits.
//  Revision    : 1.0  initial release
// ============================================================================
module bin8_to_bcd3
    import matrix_pkg::*;
(
    input  logic [7:0] bin_in,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] ndigits
);

    logic [7:0] w_rem_h;
    logic [7:0] w_rem_t;

    // Peel off hundreds, then tens with binary-weighted steps 80/40/20/10.
    always_comb begin
        hundreds = 2'd0;
        w_rem_h  = bin_in;
        if (bin_in >= 8'd200) begin
            hundreds = 2'd2;
            w_rem_h  = bin_in - 8'd200;
        end else if (bin_in >= 8'd100) begin
            hundreds = 2'd1;
            w_rem_h  = bin_in - 8'd100;
        end

        tens    = 4'd0;
        w_rem_t = w_rem_h;
        if (w_rem_t >= 8'd80) begin
            tens    = tens + 4'd8;
            w_rem_t = w_rem_t - 8'd80;
        end
        if (w_rem_t >= 8'd40) begin
            tens    = tens + 4'd4;
            w_rem_t = w_rem_t - 8'd40;
        end
        if (w_rem_t >= 8'd20) begin
            tens    = tens + 4'd2;
            w_rem_t = w_rem_t - 8'd20;
        end
        if (w_rem_t >= 8'd10) begin
            tens    = tens + 4'd1;
            w_rem_t = w_rem_t - 8'd10;
        end
        // remainder is below 10 here, so the low nibble holds it exactly
        ones = 4'(w_rem_t);

        if (hundreds != 2'd0) begin
            ndigits = 2'd3;
        end else if (tens != 4'd0) begin
            ndigits = 2'd2;
        end else begin
            ndigits = 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_display_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_display_fmt
//  Description : Reads one stored matrix element by element and streams it as
//                decimal ASCII text (space separated, CR LF per row) over a
//                valid/ready byte interface.
//  Revision    : 1.0  initial release
// ============================================================================
module matrix_display_fmt
    import matrix_pkg::*;
#(
    parameter int         MAX_DIM     = matrix_pkg::MAX_DIM,
    parameter logic [7:0] SEP_CHAR    = matrix_pkg::CHAR_SP,
    parameter int         ACK_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       disp_req,
    input  logic [3:0] disp_id,
    input  logic [2:0] disp_m,
    input  logic [2:0] disp_n,
    output logic       start_disp,
    output logic [3:0] matrix_id_in,
    output logic       read_en,
    input  logic [7:0] data_out,
    input  logic       meta_info_valid,
    input  logic       error_flag,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int               ACK_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_MAX = ACK_W'(ACK_TIMEOUT);
    localparam logic [2:0]       DIM_MAX = 3'(MAX_DIM);

    disp_state_e      state_q, state_d;
    logic [2:0]       m_q, m_d, n_q, n_d;
    logic [2:0]       row_q, row_d, col_q, col_d;
    logic [2:0]       ch_q, ch_d;
    logic [ACK_W-1:0] ack_q, ack_d;
    logic [7:0]       val_q, val_d;
    logic [3:0]       matrix_id_q, matrix_id_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             start_disp_q, start_disp_d;
    logic             read_en_q, read_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0] w_hund;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [1:0] w_ndig;
    logic       w_last_col;
    logic       w_last_row;
    logic       w_dims_ok;
    logic [2:0] w_last_idx;

    bin8_to_bcd3 u_bcd (
        .bin_in   (val_q),
        .hundreds (w_hund),
        .tens     (w_tens),
        .ones     (w_ones),
        .ndigits  (w_ndig)
    );

    // Byte idx of the current element's text: digits first, then separator or CR LF.
    function automatic logic [7:0] pick_char(
        input logic [2:0] idx,
        input logic [1:0] nd,
        input logic [1:0] h,
        input logic [3:0] t,
        input logic [3:0] o,
        input logic       last_col
    );
        logic [2:0] pos;
        logic [7:0] c;
        c   = CHAR_LF;
        pos = 3'd0;
        if (idx < {1'b0, nd}) begin
            // shift so that position 0 is always the hundreds digit
            pos = idx + 3'd3 - {1'b0, nd};
            case (pos)
                3'd0:    c = CHAR_0 + {6'd0, h};
                3'd1:    c = CHAR_0 + {4'd0, t};
                default: c = CHAR_0 + {4'd0, o};
            endcase
        end else if (last_col) begin
            c = (idx == {1'b0, nd}) ? CHAR_CR : CHAR_LF;
        end else begin
            c = SEP_CHAR;
        end
        return c;
    endfunction

    // Element/row position decode shared by the emit logic.
    always_comb begin
        w_last_col = (col_q == n_q - 3'd1);
        w_last_row = (row_q == m_q - 3'd1);
        w_dims_ok  = (disp_m != 3'd0) && (disp_m <= DIM_MAX) &&
                     (disp_n != 3'd0) && (disp_n <= DIM_MAX);
        w_last_idx = {1'b0, w_ndig} + {2'b00, w_last_col} - 3'd1 + 3'd1;
    end

    // Next-state and next-output logic for the display sequencer.
    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        n_d          = n_q;
        row_d        = row_q;
        col_d        = col_q;
        ch_d         = ch_q;
        ack_d        = ack_q;
        val_d        = val_q;
        matrix_id_d  = matrix_id_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        busy_d       = busy_q;
        start_disp_d = 1'b0;
        read_en_d    = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (disp_req) begin
                    m_d = disp_m;
                    n_d = disp_n;
                    if (w_dims_ok) begin
                        matrix_id_d  = disp_id;
                        busy_d       = 1'b1;
                        start_disp_d = 1'b1;
                        row_d        = 3'd0;
                        col_d        = 3'd0;
                        ch_d         = 3'd0;
                        state_d      = ST_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                ack_d   = '0;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                // a rejection outranks an acceptance seen in the same cycle
                if (error_flag || (!meta_info_valid && ack_q == ACK_MAX)) begin
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    tx_valid_d = 1'b0;
                    state_d    = ST_ABORT;
                end else if (meta_info_valid) begin
                    read_en_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end

            ST_FETCH: begin
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                val_d   = data_out;
                ch_d    = 3'd0;
                state_d = ST_EMIT;
            end

            ST_EMIT: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = pick_char(ch_q, w_ndig, w_hund, w_tens, w_ones, w_last_col);
                end else if (tx_ready) begin
                    if (ch_q == w_last_idx) begin
                        tx_valid_d = 1'b0;
                        ch_d       = 3'd0;
                        if (w_last_col) begin
                            col_d = 3'd0;
                            if (w_last_row) begin
                                row_d   = 3'd0;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = ST_IDLE;
                            end else begin
                                row_d     = row_q + 3'd1;
                                read_en_d = 1'b1;
                                state_d   = ST_FETCH;
                            end
                        end else begin
                            col_d     = col_q + 3'd1;
                            read_en_d = 1'b1;
                            state_d   = ST_FETCH;
                        end
                    end else begin
                        ch_d      = ch_q + 3'd1;
                        tx_data_d = pick_char(ch_q + 3'd1, w_ndig, w_hund, w_tens, w_ones,
                                              w_last_col);
                    end
                end
            end

            ST_ABORT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any element in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_q          <= 3'd0;
            n_q          <= 3'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            ch_q         <= 3'd0;
            ack_q        <= '0;
            val_q        <= 8'd0;
            matrix_id_q  <= 4'd0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            start_disp_q <= 1'b0;
            read_en_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            n_q          <= n_d;
            row_q        <= row_d;
            col_q        <= col_d;
            ch_q         <= ch_d;
            ack_q        <= ack_d;
            val_q        <= val_d;
            matrix_id_q  <= matrix_id_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            start_disp_q <= start_disp_d;
            read_en_q    <= read_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign start_disp   = start_disp_q;
    assign matrix_id_in = matrix_id_q;
    assign read_en      = read_en_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
`default_nettype wire
